// File: rtl/sim_step_scheduler.sv
// Paces the spring-mass simulation: fixed-rate tick, broadcast step start, done collection,
// req/ack frame handoff to the display, per-step button freeze and sticky overrun/timeout flags.
module sim_step_scheduler #(
  parameter int N_PARTICLES = 4,
  parameter int STEP_PERIOD = 1_000_000,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_up,
  input  logic                   btn_down,
  output logic                   btn_left_q,
  output logic                   btn_right_q,
  output logic                   btn_up_q,
  output logic                   btn_down_q,
  output logic [N_PARTICLES-1:0] step_start,
  input  logic [N_PARTICLES-1:0] particle_done,
  output logic                   frame_req,
  input  logic                   frame_ack,
  output logic                   busy,
  output logic [15:0]            step_count,
  output logic                   overrun,
  output logic                   timeout_err,
  input  logic                   clear_err
);

  localparam int PW = $clog2(STEP_PERIOD);
  localparam int RW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(STEP_PERIOD - 1);
  localparam logic [RW-1:0] RUN_LAST    = RW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_START,
    S_RUN,
    S_FRAME
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          period_q, period_d;
  logic [N_PARTICLES-1:0] mask_q, mask_d;
  logic [RW-1:0]          run_cnt_q, run_cnt_d;
  logic [15:0]            step_count_q, step_count_d;
  logic [3:0]             btn_lat_q, btn_lat_d;
  logic                   overrun_q, overrun_d;
  logic                   timeout_err_q, timeout_err_d;

  logic                   tick;
  logic                   set_overrun;
  logic                   set_timeout;
  logic [N_PARTICLES-1:0] mask_all;

  assign tick     = (period_q == PERIOD_LAST);
  assign mask_all = mask_q | particle_done;

  always_comb begin
    state_d       = state_q;
    period_d      = '0;
    mask_d        = mask_q;
    run_cnt_d     = run_cnt_q;
    step_count_d  = step_count_q;
    btn_lat_d     = btn_lat_q;
    set_overrun   = 1'b0;
    set_timeout   = 1'b0;

    if (enable) begin
      period_d = tick ? '0 : period_q + PW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (!enable)   state_d = S_IDLE;
        else if (tick) state_d = S_START;
      end
      S_START: begin
        set_overrun = tick;
        btn_lat_d   = {btn_left, btn_right, btn_up, btn_down};
        mask_d      = '0;
        run_cnt_d   = '0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        set_overrun = tick;
        mask_d      = mask_all;
        run_cnt_d   = run_cnt_q + RW'(1);
        // A complete mask on the last allowed cycle still counts as on time.
        if (&mask_all) begin
          state_d = S_FRAME;
        end else if (run_cnt_q == RUN_LAST) begin
          set_timeout = 1'b1;
          state_d     = S_FRAME;
        end
      end
      S_FRAME: begin
        set_overrun = tick;
        if (frame_ack) begin
          step_count_d = step_count_q + 16'd1;
          state_d      = enable ? S_WAIT_TICK : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    overrun_d     = set_overrun | (overrun_q & ~clear_err);
    timeout_err_d = set_timeout | (timeout_err_q & ~clear_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      period_q      <= '0;
      mask_q        <= '0;
      run_cnt_q     <= '0;
      step_count_q  <= '0;
      btn_lat_q     <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      mask_q        <= mask_d;
      run_cnt_q     <= run_cnt_d;
      step_count_q  <= step_count_d;
      btn_lat_q     <= btn_lat_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign step_start  = {N_PARTICLES{state_q == S_START}};
  assign frame_req   = (state_q == S_FRAME);
  assign busy        = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_FRAME);
  assign step_count  = step_count_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;
  assign btn_left_q  = btn_lat_q[3];
  assign btn_right_q = btn_lat_q[2];
  assign btn_up_q    = btn_lat_q[1];
  assign btn_down_q  = btn_lat_q[0];

endmodule

// File: tb/tb_sim_step_scheduler.sv
// Bench for sim_step_scheduler: table of step scenarios, randomized steps against a
// timeline model, then enable-drop and asynchronous-reset sequences.
module tb_sim_step_scheduler;

  localparam int N     = 3;
  localparam int P     = 8;
  localparam int T     = 6;
  localparam int NT    = 8;
  localparam int NEVER = 99;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         btn_left, btn_right, btn_up, btn_down;
  logic         btn_left_q, btn_right_q, btn_up_q, btn_down_q;
  logic [N-1:0] step_start;
  logic [N-1:0] particle_done;
  logic         frame_req;
  logic         frame_ack;
  logic         busy;
  logic [15:0]  step_count;
  logic         overrun;
  logic         timeout_err;
  logic         clear_err;

  sim_step_scheduler #(
    .N_PARTICLES(N),
    .STEP_PERIOD(P),
    .TIMEOUT    (T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left_q   (btn_left_q),
    .btn_right_q  (btn_right_q),
    .btn_up_q     (btn_up_q),
    .btn_down_q   (btn_down_q),
    .step_start   (step_start),
    .particle_done(particle_done),
    .frame_req    (frame_req),
    .frame_ack    (frame_ack),
    .busy         (busy),
    .step_count   (step_count),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .clear_err    (clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per step: done arrival per particle (RUN cycles after entry), ack wait,
  // btn_left held only for the START edge, clear after ack; then expected results.
  typedef struct {
    int d0, d1, d2;
    int w;
    bit btn;
    bit clr;
    int off;
    bit to;
    bit ov;
    int cnt;
    int gap;
  } vec_t;

  vec_t tbl [NT];
  vec_t cur;

  int vectors;
  int miscompares;

  int   n;
  int   pc;
  bit   in_step;
  bit   tbl_step;
  int   tbl_i;
  int   s, f, a, D, w;
  int   d [3];
  int   f_obs;
  logic to_at_f, btn_at_f;
  bit   exp_ov, exp_to;
  int   exp_cnt;
  logic [3:0] exp_btn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  // One clock: advance the step timeline, compare every output, drive next inputs.
  task automatic engine_cycle();
    bit tick, set_ov, set_to, noise;
    cyc();
    tick   = (pc == P - 1);
    pc     = enable ? (tick ? 0 : pc + 1) : 0;
    set_ov = 1'b0;
    set_to = 1'b0;

    if (in_step && n == a) begin
      set_ov  = tick;
      exp_cnt = (exp_cnt + 1) % 65536;
      in_step = 1'b0;
      if (tbl_step) begin
        chk("tbl_frame_offset", f_obs - s, cur.off);
        chk("tbl_timeout_at_frame", to_at_f, cur.to);
        chk("tbl_btn_left_q", btn_at_f, cur.btn);
        chk("tbl_overrun_at_ack", overrun, cur.ov);
        chk("tbl_step_count", step_count, cur.cnt);
      end
    end else if (in_step) begin
      set_ov = tick;
      if (n == f && D > T - 1) set_to = 1'b1;
      if (n == s + 1) exp_btn = {btn_left, btn_right, btn_up, btn_down};
    end else if (tick) begin
      if (s >= 0 && tbl_step) chk("tbl_step_gap", n - s, cur.gap);
      s       = n;
      in_step = 1'b1;
      f_obs   = -1;
      if (tbl_i < NT) begin
        cur      = tbl[tbl_i];
        tbl_i++;
        tbl_step = 1'b1;
        d[0] = cur.d0; d[1] = cur.d1; d[2] = cur.d2;
        w    = cur.w;
      end else begin
        tbl_step = 1'b0;
        for (int i = 0; i < 3; i++)
          d[i] = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 5));
        w = $urandom_range(0, 14);
      end
      D = 0;
      for (int i = 0; i < 3; i++) if (d[i] > D) D = d[i];
      f = s + 2 + ((D < T - 1) ? D : T - 1);
      a = f + 1 + w;
    end

    exp_ov = set_ov ? 1'b1 : (clear_err ? 1'b0 : exp_ov);
    exp_to = set_to ? 1'b1 : (clear_err ? 1'b0 : exp_to);

    chk("step_start", step_start, (in_step && n == s) ? 3'b111 : 3'b000);
    chk("frame_req", frame_req, in_step && n >= f);
    chk("busy", busy, in_step);
    chk("step_count", step_count, exp_cnt);
    chk("overrun", overrun, exp_ov);
    chk("timeout_err", timeout_err, exp_to);
    chk("btn_q", {btn_left_q, btn_right_q, btn_up_q, btn_down_q}, exp_btn);

    if (in_step && f_obs < 0 && frame_req === 1'b1) begin
      f_obs    = n;
      to_at_f  = timeout_err;
      btn_at_f = btn_left_q;
    end

    noise = !tbl_step && !(in_step && n + 1 >= s + 2 && n + 1 <= f);
    particle_done = noise ? 3'($urandom) : 3'b000;
    if (in_step)
      for (int i = 0; i < 3; i++)
        if (n + 1 == s + 2 + d[i]) particle_done[i] = 1'b1;

    if (in_step && n + 1 == a)                         frame_ack = 1'b1;
    else if (!tbl_step && !(in_step && n + 1 > f))     frame_ack = ($urandom_range(0, 3) == 0);
    else                                               frame_ack = 1'b0;

    if (tbl_step)
      {btn_left, btn_right, btn_up, btn_down} = (in_step && n + 1 == s + 1 && cur.btn) ? 4'b1000 : 4'b0000;
    else
      {btn_left, btn_right, btn_up, btn_down} = 4'($urandom);

    if (tbl_step) clear_err = (!in_step && n == a) ? cur.clr : 1'b0;
    else          clear_err = ($urandom_range(0, 11) == 0);
  endtask

  task automatic wait_start(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc();
      if (step_start === 3'b111) ok = 1'b1;
    end
    chk(name, ok, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_step_start"}, step_start, 3'b000);
    chk({tag, "_frame_req"}, frame_req, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_step_count"}, step_count, 16'd0);
    chk({tag, "_overrun"}, overrun, 1'b0);
    chk({tag, "_timeout_err"}, timeout_err, 1'b0);
    chk({tag, "_btn_q"}, {btn_left_q, btn_right_q, btn_up_q, btn_down_q}, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    //            d0 d1 d2     w btn clr off to ov cnt gap
    tbl[0] = '{0, 0, 0,      0, 1, 0,  2, 0, 0, 1,  8};
    tbl[1] = '{0, 0, 0,      0, 0, 0,  2, 0, 0, 2,  8};
    tbl[2] = '{0, 0, 0,      0, 1, 0,  2, 0, 0, 3,  8};
    tbl[3] = '{0, 2, 1,      0, 0, 0,  4, 0, 0, 4,  8};
    tbl[4] = '{1, 0, NEVER,  0, 0, 1,  7, 1, 1, 5, 16};
    tbl[5] = '{0, 0, 0,     12, 1, 1,  2, 0, 1, 6, 16};
    tbl[6] = '{5, 5, 5,      0, 0, 1,  7, 0, 1, 7, 16};
    tbl[7] = '{3, 1, 0,      1, 0, 0,  5, 0, 0, 8,  8};

    vectors = 0; miscompares = 0;
    n = 0; pc = 0; in_step = 1'b0; tbl_step = 1'b0; tbl_i = 0;
    s = -1; f = -1; a = -1; D = 0; w = 0; f_obs = -1;
    exp_ov = 1'b0; exp_to = 1'b0; exp_cnt = 0; exp_btn = 4'b0000;
    to_at_f = 1'b0; btn_at_f = 1'b0;

    reset = 1'b1; enable = 1'b0; frame_ack = 1'b0; clear_err = 1'b0;
    particle_done = '0;
    {btn_left, btn_right, btn_up, btn_down} = 4'b1111;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    reset = 1'b0;
    enable = 1'b1;
    {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
    n = 0;

    for (int c = 0; c < 300 && !(tbl_i == NT && !in_step); c++) engine_cycle();
    chk("tbl_complete", (tbl_i == NT) && !in_step, 1'b1);

    repeat (1500) engine_cycle();
    for (int c = 0; c < 60 && in_step; c++) engine_cycle();
    chk("random_drain", in_step, 1'b0);

    // Enable dropped mid-RUN: the step still finishes, then the block parks in IDLE.
    particle_done = '0; frame_ack = 1'b0; clear_err = 1'b0;
    {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
    wait_start("hs_a_start");
    cyc();
    enable = 1'b0;
    cyc();
    chk("hs_a_run_busy", busy, 1'b1);
    chk("hs_a_run_no_req", frame_req, 1'b0);
    particle_done = 3'b111;
    cyc();
    particle_done = 3'b000;
    chk("hs_a_frame_req", frame_req, 1'b1);
    frame_ack = 1'b1;
    cyc();
    frame_ack = 1'b0;
    exp_cnt = (exp_cnt + 1) % 65536;
    chk("hs_a_req_drop", frame_req, 1'b0);
    chk("hs_a_idle_busy", busy, 1'b0);
    chk("hs_a_step_count", step_count, exp_cnt);
    bad = 0;
    repeat (20) begin
      cyc();
      if (busy !== 1'b0 || step_start !== 3'b000) bad++;
    end
    chk("hs_a_stays_idle", bad, 0);

    // Enable dropped mid-RUN again, then asynchronous reset while sitting in FRAME.
    enable = 1'b1;
    {btn_left, btn_right, btn_up, btn_down} = 4'b1111;
    wait_start("hs_b_start");
    cyc();
    {btn_left, btn_right, btn_up, btn_down} = 4'b0000;
    enable = 1'b0;
    particle_done = 3'b111;
    cyc();
    particle_done = 3'b000;
    cyc();
    cyc();
    chk("hs_b_frame_req", frame_req, 1'b1);
    chk("hs_b_busy", busy, 1'b1);
    chk("hs_b_btn_q", {btn_left_q, btn_right_q, btn_up_q, btn_down_q}, 4'b1111);
    chk("hs_b_step_count", step_count, exp_cnt);
    #2 reset = 1'b1;
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      cyc();
      if (busy !== 1'b0 || frame_req !== 1'b0 || step_count !== 16'd0) bad++;
    end
    chk("post_reset_idle", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
